// File: rtl/snn_inference_ctrl_pkg.sv
// Shared types and constants for the SNN inference sequencer: FSM states,
// LFSR polynomial/seed and the Galois step used by every encoder LFSR.
package snn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_POLY      = 16'hB400;
    localparam logic [15:0] LFSR_SEED_BASE = 16'hACE1;
    localparam int          RATE_W         = 8;

    // Right-shifting Galois step: feed the dropped LSB back through the tap mask.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Host-side bundle of the inference sequencer: run request, programming
// values and the result/status signals returned to the register side.
interface snn_inference_ctrl_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2,
    parameter int T_W   = 8,
    parameter int CNT_W = 8
);
    import snn_ctrl_pkg::*;

    localparam int WIN_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    logic                     start;
    logic                     abort;
    logic [T_W-1:0]           n_steps;
    logic [N_IN*RATE_W-1:0]   rate;
    logic                     busy;
    logic                     done;
    logic [N_OUT*CNT_W-1:0]   count;
    logic [WIN_W-1:0]         winner;
    logic                     no_spike;

    modport master (
        output start, abort, n_steps, rate,
        input  busy, done, count, winner, no_spike
    );

    modport slave (
        input  start, abort, n_steps, rate,
        output busy, done, count, winner, no_spike
    );

endinterface

// File: rtl/snn_inference_ctrl_lfsr.sv
// 16-bit Galois LFSR used as the Bernoulli source for one network input;
// reloadable from a seed and advanced only when step is high.
module snn_lfsr16
    import snn_ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_SEED = LFSR_SEED_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_SEED;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Sequencer for one SNN inference: clears the core, rate-encodes inputs with
// LFSRs for n_steps cycles, drains, then reports saturating counts and argmax.
module snn_inference_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int N_IN         = 2,
    parameter int N_OUT        = 2,
    parameter int T_W          = 8,
    parameter int CNT_W        = 8,
    parameter int CLR_CYCLES   = 2,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    snn_inference_ctrl_if.slave  host,
    input  logic [N_OUT-1:0]     net_spike_out,
    output logic [N_IN-1:0]      net_spike_in,
    output logic                 net_rst_n
);

    localparam int WIN_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int CYC_W = max_int(T_W, max_int($clog2(DRAIN_CYCLES + 1),
                                                $clog2(CLR_CYCLES + 1)));

    state_t                 state, state_next;
    logic [CYC_W-1:0]       cyc;
    logic [T_W-1:0]         n_steps_q;
    logic [N_IN*RATE_W-1:0] rate_q;
    logic [CNT_W-1:0]       cnt_nxt [N_OUT];
    logic [WIN_W-1:0]       best_idx, winner_q;
    logic [CNT_W-1:0]       best_val;
    logic                   any_spike, no_spike_q;
    logic                   accept, abort_run, last_cyc;
    logic                   lfsr_load, lfsr_step, count_en, run_phase;
    logic [15:0]            lfsr_q [N_IN];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept    = (state == ST_IDLE) && host.start;
    assign abort_run = host.abort &&
                       (state == ST_CLEAR || state == ST_RUN || state == ST_DRAIN);
    assign last_cyc  = (cyc == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (host.start) state_next = ST_CLEAR;
            ST_CLEAR: if (host.abort) state_next = ST_IDLE;
                      else if (last_cyc) state_next = (n_steps_q == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (host.abort) state_next = ST_IDLE;
                      else if (last_cyc) state_next = ST_DRAIN;
            ST_DRAIN: if (host.abort) state_next = ST_IDLE;
                      else if (last_cyc) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        host.busy = 1'b0;
        host.done = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        count_en  = 1'b0;
        run_phase = 1'b0;
        case (state)
            ST_CLEAR: begin host.busy = 1'b1; lfsr_load = 1'b1; end
            ST_RUN:   begin host.busy = 1'b1; lfsr_step = 1'b1; count_en = 1'b1; run_phase = 1'b1; end
            ST_DRAIN: begin host.busy = 1'b1; count_en = 1'b1; end
            ST_DONE:  host.done = 1'b1;
            default:  ;
        endcase
    end

    // Per-phase down-counter: reloaded on every state change, exit when it hits 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= '0;
        end else if (state_next != state) begin
            case (state_next)
                ST_CLEAR: cyc <= CYC_W'(CLR_CYCLES - 1);
                ST_RUN:   cyc <= CYC_W'(n_steps_q) - 1'b1;
                ST_DRAIN: cyc <= CYC_W'(DRAIN_CYCLES - 1);
                default:  cyc <= '0;
            endcase
        end else if (!last_cyc) begin
            cyc <= cyc - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            n_steps_q <= host.n_steps;
            rate_q    <= host.rate;
        end
    end

    // Registered so the core reset is glitch-free; low only while CLEAR is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) net_rst_n <= 1'b0;
        else        net_rst_n <= (state_next != ST_CLEAR);
    end

    for (genvar i = 0; i < N_IN; i++) begin : g_enc
        snn_lfsr16 #(
            .RESET_SEED (LFSR_SEED_BASE + 16'(i))
        ) u_lfsr (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (lfsr_load),
            .seed  (LFSR_SEED_BASE + 16'(i)),
            .step  (lfsr_step),
            .q     (lfsr_q[i])
        );
        assign net_spike_in[i] = run_phase && (lfsr_q[i][RATE_W-1:0] < rate_q[i*RATE_W +: RATE_W]);
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt_r;
        assign cnt_nxt[k] = (count_en && net_spike_out[k]) ? sat_inc(cnt_r) : cnt_r;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                 cnt_r <= '0;
            else if (accept || abort_run) cnt_r <= '0;
            else                        cnt_r <= cnt_nxt[k];
        end
        assign host.count[k*CNT_W +: CNT_W] = cnt_r;
    end

    // Scan the post-update counts so the final DRAIN sample is part of the result.
    always_comb begin
        best_idx  = '0;
        best_val  = cnt_nxt[0];
        any_spike = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (cnt_nxt[k] != '0) any_spike = 1'b1;
            if (cnt_nxt[k] > best_val) begin
                best_val = cnt_nxt[k];
                best_idx = WIN_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner_q   <= '0;
            no_spike_q <= 1'b0;
        end else if (accept || abort_run) begin
            winner_q   <= '0;
            no_spike_q <= 1'b0;
        end else if (state == ST_DRAIN && state_next == ST_DONE) begin
            winner_q   <= any_spike ? best_idx : '0;
            no_spike_q <= !any_spike;
        end
    end

    assign host.winner   = winner_q;
    assign host.no_spike = no_spike_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Bench for snn_inference_ctrl: table-driven runs plus randomized runs
// scored against a spike-train model, with abort and mid-run reset sequences.
module tb_snn_inference_ctrl;

    localparam int N_IN = 2, N_OUT = 2, T_W = 8, CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    snn_inference_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT), .T_W(T_W), .CNT_W(CNT_W)) host_if ();

    logic [N_OUT-1:0] net_spike_out;
    logic [N_IN-1:0]  net_spike_in;
    logic             net_rst_n;
    logic [1:0]       lb;
    int               stub_mode;

    // Core stub: loopback delayed one cycle, or constant all-ones outputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lb <= 2'b00;
        else        lb <= net_spike_in;
    end
    assign net_spike_out = (stub_mode == 1) ? 2'b11 : lb;

    snn_inference_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .T_W(T_W), .CNT_W(CNT_W),
        .CLR_CYCLES(2), .DRAIN_CYCLES(16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host          (host_if),
        .net_spike_out (net_spike_out),
        .net_spike_in  (net_spike_in),
        .net_rst_n     (net_rst_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: each input is a Bernoulli train from its own LFSR sequence.
    bit exp_spk [2][300];
    int exp_cnt [2];
    int exp_win, exp_nsp;

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model(input int n, input int r0, input int r1, input int mode);
        logic [15:0] s;
        int c, r;
        for (int i = 0; i < 2; i++) begin
            s = 16'hACE1 + 16'(i);
            r = (i == 0) ? r0 : r1;
            c = 0;
            for (int j = 0; j < n; j++) begin
                exp_spk[i][j] = (int'(s[7:0]) < r);
                if (exp_spk[i][j]) c++;
                s = galois(s);
            end
            if (mode == 1) c = n + 16;
            exp_cnt[i] = (c > 255) ? 255 : c;
        end
        exp_win = 0;
        for (int i = 1; i < 2; i++) if (exp_cnt[i] > exp_cnt[exp_win]) exp_win = i;
        exp_nsp = (exp_cnt[0] == 0 && exp_cnt[1] == 0) ? 1 : 0;
    endtask

    task automatic do_run(input string tag, input int n, input int r0, input int r1,
                          input int mode, input int exp_lat, input bit poke);
        int done_at, dones, busy_cyc, rst_low, spk_err, c0, c1, w, ns, post_busy;
        logic [1:0] want;
        logic [7:0] r0b, r1b, nb;
        r0b = r0[7:0];
        r1b = r1[7:0];
        nb  = n[7:0];
        model(n, r0, r1, mode);
        stub_mode = mode;
        @(negedge clk);
        host_if.n_steps = nb;
        host_if.rate    = {r1b, r0b};
        host_if.start   = 1'b1;
        @(posedge clk);
        #1 host_if.start = 1'b0;
        done_at = -1; dones = 0; busy_cyc = 0; rst_low = 0; spk_err = 0;
        c0 = -1; c1 = -1; w = -1; ns = -1; post_busy = -1;
        for (int k = 1; k <= exp_lat + 40; k++) begin
            @(negedge clk);
            if (poke) host_if.start = (k == 5);
            if (host_if.busy === 1'b1) busy_cyc++;
            if (net_rst_n !== 1'b1) rst_low++;
            want = 2'b00;
            if (k - 3 >= 0 && k - 3 < n) want = {exp_spk[1][k-3], exp_spk[0][k-3]};
            if (net_spike_in !== want) spk_err++;
            if (done_at > 0 && k == done_at + 1) post_busy = int'(host_if.busy);
            if (host_if.done === 1'b1) begin
                dones++;
                if (done_at < 0) begin
                    done_at = k;
                    c0 = int'(host_if.count[7:0]);
                    c1 = int'(host_if.count[15:8]);
                    w  = int'(host_if.winner);
                    ns = int'(host_if.no_spike);
                    if (poke) host_if.start = 1'b1;
                end
            end
        end
        host_if.start = 1'b0;
        chk({tag, "_done_latency"}, done_at, exp_lat);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_busy_cycles"}, busy_cyc, exp_lat - 1);
        chk({tag, "_net_rst_low_cycles"}, rst_low, 2);
        chk({tag, "_spike_in_errors"}, spk_err, 0);
        chk({tag, "_count0"}, c0, exp_cnt[0]);
        chk({tag, "_count1"}, c1, exp_cnt[1]);
        chk({tag, "_winner"}, w, exp_win);
        chk({tag, "_no_spike"}, ns, exp_nsp);
        chk({tag, "_busy_after_done"}, post_busy, 0);
        chk({tag, "_count0_hold"}, int'(host_if.count[7:0]), exp_cnt[0]);
        chk({tag, "_winner_hold"}, int'(host_if.winner), exp_win);
    endtask

    typedef struct {
        string tag;
        int    n;
        int    r0;
        int    r1;
        int    mode;
        int    lat;
        bit    poke;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, seen, r0, r1;
        vecs[0] = '{"zero_rate", 20,   0,   0, 0,  39, 1'b0};
        vecs[1] = '{"skewed",   100, 255,   0, 0, 119, 1'b1};
        vecs[2] = '{"saturate", 255,   0,   0, 1, 274, 1'b0};
        vecs[3] = '{"zero_steps", 0, 200, 200, 0,  19, 1'b0};
        vecs[4] = '{"winner1",   60,  10, 200, 0,  79, 1'b0};

        host_if.start = 1'b0; host_if.abort = 1'b0;
        host_if.n_steps = '0; host_if.rate = '0;
        stub_mode = 0;

        #12;
        chk("rst_net_rst_n", int'(net_rst_n), 0);
        chk("rst_busy", int'(host_if.busy), 0);
        chk("rst_done", int'(host_if.done), 0);
        chk("rst_count", int'(host_if.count), 0);
        chk("rst_winner", int'(host_if.winner), 0);
        chk("rst_no_spike", int'(host_if.no_spike), 0);
        chk("rst_spike_in", int'(net_spike_in), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_net_rst_n", int'(net_rst_n), 1);

        for (int v = 0; v < 5; v++)
            do_run(vecs[v].tag, vecs[v].n, vecs[v].r0, vecs[v].r1, vecs[v].mode, vecs[v].lat, vecs[v].poke);

        // Abort during RUN cycle 5.
        stub_mode = 0;
        @(negedge clk);
        host_if.n_steps = 8'd50; host_if.rate = {8'd128, 8'd128}; host_if.start = 1'b1;
        @(posedge clk);
        #1 host_if.start = 1'b0;
        repeat (8) @(negedge clk);
        host_if.abort = 1'b1;
        @(posedge clk);
        #1 host_if.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(host_if.busy), 0);
        chk("abort_done", int'(host_if.done), 0);
        chk("abort_count", int'(host_if.count), 0);
        chk("abort_net_rst_n", int'(net_rst_n), 1);
        chk("abort_spike_in", int'(net_spike_in), 0);
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (host_if.done === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
        do_run("after_abort", 30, 180, 90, 0, 49, 1'b0);

        // Abort in IDLE leaves held results untouched.
        @(negedge clk) host_if.abort = 1'b1;
        @(negedge clk) host_if.abort = 1'b0;
        chk("idle_abort_count0", int'(host_if.count[7:0]), exp_cnt[0]);
        chk("idle_abort_busy", int'(host_if.busy), 0);

        // Asynchronous reset in the middle of DRAIN.
        @(negedge clk);
        host_if.n_steps = 8'd10; host_if.rate = {8'd255, 8'd255}; host_if.start = 1'b1;
        @(posedge clk);
        #1 host_if.start = 1'b0;
        repeat (16) @(negedge clk);
        chk("pre_rst_busy", int'(host_if.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_net_rst_n", int'(net_rst_n), 0);
        chk("midrst_busy", int'(host_if.busy), 0);
        chk("midrst_count", int'(host_if.count), 0);
        chk("midrst_winner", int'(host_if.winner), 0);
        chk("midrst_no_spike", int'(host_if.no_spike), 0);
        @(negedge clk);
        chk("midrst_hold_net_rst_n", int'(net_rst_n), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_net_rst_n", int'(net_rst_n), 1);
        chk("midrst_release_done", int'(host_if.done), 0);
        do_run("after_reset", 12, 255, 255, 0, 31, 1'b0);

        for (int r = 0; r < 4; r++) begin
            n  = int'($urandom_range(1, 60));
            r0 = int'($urandom_range(0, 255));
            r1 = int'($urandom_range(0, 255));
            do_run("random", n, r0, r1, 0, 19 + n, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
